// File: rtl/fp_norm_round_pipe_pkg.sv
// Shared FP32 constants for the multiplier datapath: encoding constants for
// packing binary32 results and the product/shift/exponent widths shared by
// the multiplier, the leading-zero detector and the normalize/round stage.
package fp_norm_round_pipe_pkg;

  localparam int          FP32_BIAS    = 127;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam int          FP32_FRAC_W  = 23;

  localparam int          FP32_PROD_W  = 48;
  localparam int          FP32_SHIFT_W = 6;
  localparam int          FP32_EXP_W   = 10;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a pre-rounding fraction.
// Ports:
//   frac_pre - truncated fraction (hidden bit already removed)
//   guard    - first bit below the fraction lsb
//   sticky   - OR of all bits below guard
//   e1       - signed exponent before rounding
//   frac     - rounded fraction
//   e2       - signed exponent after rounding (bumped on mantissa carry-out)
module fp_round_rne #(
  parameter int FRAC_W = 23,
  parameter int EXP_W  = 10
) (
  input  logic        [FRAC_W-1:0] frac_pre,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed [EXP_W-1:0]  e1,
  output logic        [FRAC_W-1:0] frac,
  output logic signed [EXP_W-1:0]  e2
);

  logic              inc;
  logic [FRAC_W:0]   sum;
  logic              carry;

  // Round up above the halfway point, or exactly at it when the lsb is odd.
  assign inc   = guard & (sticky | frac_pre[0]);
  assign sum   = {1'b0, frac_pre} + {{FRAC_W{1'b0}}, inc};
  assign carry = sum[FRAC_W];

  // A carry-out means the mantissa rolled over to 2.0: fraction becomes zero
  // and the exponent moves up by one.
  assign frac  = carry ? '0 : sum[FRAC_W-1:0];
  assign e2    = carry ? e1 + EXP_W'(1) : e1;

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Normalize / round / pack stage of the FP32 multiplier datapath.
// Two registered stages with valid/ready handshaking:
//   stage 1 normalizes the 48-bit product using the LZD shift and forms the
//           pre-rounding fraction, guard, sticky and exponent;
//   stage 2 rounds (RNE), resolves specials/overflow/flush-to-zero and
//           registers the packed binary32 word.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid / in_ready      - upstream handshake
//   in_sign, in_exp          - product sign, signed provisional biased exponent
//   in_prod, in_shift        - mantissa product, LZD shift (leading zeros + 1)
//   in_is_nan/inf/zero       - special-case flags from operand decode
//   out_valid / out_ready    - downstream handshake
//   out_data                 - packed FP32 result
module fp_norm_round_pipe
  import fp_norm_round_pipe_pkg::*;
#(
  parameter int PROD_W  = FP32_PROD_W,
  parameter int SHIFT_W = FP32_SHIFT_W,
  parameter int EXP_W   = FP32_EXP_W,
  parameter int FRAC_W  = FP32_FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic signed [EXP_W-1:0]  in_exp,
  input  logic        [PROD_W-1:0] in_prod,
  input  logic       [SHIFT_W-1:0] in_shift,
  input  logic                     in_is_nan,
  input  logic                     in_is_inf,
  input  logic                     in_is_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic              [31:0] out_data
);

  localparam int GRD_BIT = PROD_W - FRAC_W - 1;

  localparam logic signed [EXP_W-1:0] EXP_OVF = EXP_W'(2 * FP32_BIAS + 1);
  localparam logic signed [EXP_W-1:0] EXP_UNF = '0;

  function automatic logic [31:0] pack_fp32(
    input logic                     sign,
    input logic                     nan,
    input logic                     inf,
    input logic                     zero,
    input logic signed [EXP_W-1:0]  e2,
    input logic        [FRAC_W-1:0] frac
  );
    logic [31:0] res;
    if (nan)                res = FP32_QNAN;
    else if (inf)           res = {sign, FP32_EXP_MAX, {FRAC_W{1'b0}}};
    else if (zero)          res = {sign, 31'h0};
    else if (e2 >= EXP_OVF) res = {sign, FP32_EXP_MAX, {FRAC_W{1'b0}}};
    else if (e2 <= EXP_UNF) res = {sign, 31'h0};
    else                    res = {sign, e2[7:0], frac};
    return res;
  endfunction

  logic                     vld_p1;
  logic                     sign_p1;
  logic                     nan_p1;
  logic                     inf_p1;
  logic                     zero_p1;
  logic        [FRAC_W-1:0] frac_pre_p1;
  logic                     guard_p1;
  logic                     sticky_p1;
  logic signed [EXP_W-1:0]  e1_p1;

  logic                     vld_p2;
  logic              [31:0] data_p2;

  logic                     s1_adv;
  logic        [PROD_W-1:0] norm;
  logic signed [EXP_W-1:0]  shift_s;
  logic signed [EXP_W-1:0]  e1;
  logic        [FRAC_W-1:0] frac_r;
  logic signed [EXP_W-1:0]  e2_r;

  assign s1_adv   = ~vld_p2 | out_ready;
  assign in_ready = ~vld_p1 | s1_adv;

  // The shift is leading zeros + 1, so the leading one falls off the top and
  // the hidden bit is dropped for free.
  assign norm    = in_prod << in_shift;
  assign shift_s = signed'(EXP_W'(in_shift));
  assign e1      = in_exp + EXP_W'(2) - shift_s;

  // ---- stage 1: normalize ----
  always_ff @(posedge clk) begin
    if (rst)           vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      sign_p1     <= in_sign;
      nan_p1      <= in_is_nan;
      inf_p1      <= in_is_inf;
      // A zero product without the decode flag still packs as a signed zero.
      zero_p1     <= in_is_zero | (in_prod == '0);
      frac_pre_p1 <= norm[PROD_W-1 -: FRAC_W];
      guard_p1    <= norm[GRD_BIT];
      sticky_p1   <= |norm[GRD_BIT-1:0];
      e1_p1       <= e1;
    end
  end

  fp_round_rne #(
    .FRAC_W (FRAC_W),
    .EXP_W  (EXP_W)
  ) u_round (
    .frac_pre (frac_pre_p1),
    .guard    (guard_p1),
    .sticky   (sticky_p1),
    .e1       (e1_p1),
    .frac     (frac_r),
    .e2       (e2_r)
  );

  // ---- stage 2: round and pack ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (s1_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1)
        data_p2 <= pack_fp32(sign_p1, nan_p1, inf_p1, zero_p1, e2_r, frac_r);
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
module tb_fp_norm_round_pipe;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic signed [9:0]  in_exp;
  logic        [47:0] in_prod;
  logic        [5:0]  in_shift;
  logic               in_is_nan;
  logic               in_is_inf;
  logic               in_is_zero;
  logic               out_valid;
  logic               out_ready;
  logic        [31:0] out_data;

  fp_norm_round_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_prod    (in_prod),
    .in_shift   (in_shift),
    .in_is_nan  (in_is_nan),
    .in_is_inf  (in_is_inf),
    .in_is_zero (in_is_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    int          exp;
    logic [47:0] prod;
    int          shift;
    logic        nan;
    logic        inf;
    logic        zero;
    logic [31:0] expv;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int popped = 0;
  logic [31:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] held = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  // Value-level reference: take the bits that follow the leading one as an
  // integer, round it to 23 bits by comparing the discarded remainder with
  // one half, then apply the range rules on the resulting exponent.
  function automatic logic [31:0] model(input logic sign, input int exp,
                                        input logic [47:0] prod, input int shift,
                                        input logic nan, input logic inf,
                                        input logic zero);
    longint unsigned r, q, rem;
    int e;
    if (nan) return 32'h7FC00000;
    if (inf) return {sign, 8'hFF, 23'h0};
    if (zero || prod == 48'h0) return {sign, 31'h0};
    r = 64'(prod);
    r = (r << shift) & 64'h0000_FFFF_FFFF_FFFF;
    q = r >> 25;
    rem = r & 64'h1FF_FFFF;
    if (rem > 64'h100_0000 || (rem == 64'h100_0000 && q[0])) q = q + 1;
    e = exp + 2 - shift;
    if (q == 64'h80_0000) begin
      q = 0;
      e = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'h0};
    if (e <= 0) return {sign, 31'h0};
    return {sign, e[7:0], q[22:0]};
  endfunction

  function automatic vec_t mk(input logic sign, input int exp, input logic [47:0] prod,
                              input int shift, input logic nan, input logic inf,
                              input logic zero, input logic [31:0] expv);
    vec_t v;
    v.sign = sign; v.exp = exp; v.prod = prod; v.shift = shift;
    v.nan = nan; v.inf = inf; v.zero = zero; v.expv = expv;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_sign    = v.sign;
    in_exp     = 10'(v.exp);
    in_prod    = v.prod;
    in_shift   = 6'(v.shift);
    in_is_nan  = v.nan;
    in_is_inf  = v.inf;
    in_is_zero = v.zero;
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      check1("in_ready_rule", in_ready, !(exp_q.size() == 2 && !out_ready));
      if (stall_prev) begin
        check1("stall_hold_valid", out_valid, 1'b1);
        check32("stall_hold_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h want none", out_data);
        end else begin
          check32("scoreboard", out_data, exp_q.pop_front());
          popped++;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_sign, int'(in_exp), in_prod, int'(in_shift),
                              in_is_nan, in_is_inf, in_is_zero));
      stall_prev = out_valid && !out_ready;
      held = out_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  vec_t dirs[$];
  vec_t sv;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(0, 0, 48'h0, 0, 0, 0, 0, 32'h0));
    repeat (3) @(posedge clk);
    #1;
    check1("reset_out_valid", out_valid, 1'b0);
    check32("reset_out_data", out_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check1("reset_in_ready", in_ready, 1'b1);

    dirs.push_back(mk(0, 127, 48'h400000000000, 2, 0, 0, 0, 32'h3F800000)); // 1.0*1.0
    dirs.push_back(mk(0, 127, 48'h900000000000, 1, 0, 0, 0, 32'h40100000)); // 1.5*1.5
    dirs.push_back(mk(0, 127, 48'h400000400000, 2, 0, 0, 0, 32'h3F800000)); // tie, even
    dirs.push_back(mk(0, 127, 48'h400000C00000, 2, 0, 0, 0, 32'h3F800002)); // tie, odd
    dirs.push_back(mk(0, 127, 48'h400000600000, 2, 0, 0, 0, 32'h3F800001)); // above half
    dirs.push_back(mk(0, 127, 48'h7FFFFFFFFFFF, 2, 0, 0, 0, 32'h40000000)); // carry out
    dirs.push_back(mk(1, 254, 48'h800000000000, 1, 0, 0, 0, 32'hFF800000)); // overflow
    dirs.push_back(mk(0, 253, 48'h800000000000, 1, 0, 0, 0, 32'h7F000000)); // max exp
    dirs.push_back(mk(0, 254, 48'h7FFFFFFFFFFF, 2, 0, 0, 0, 32'h7F800000)); // carry to inf
    dirs.push_back(mk(0, 0,   48'h400000000000, 2, 0, 0, 0, 32'h00000000)); // flush
    dirs.push_back(mk(0, 1,   48'h400000000000, 2, 0, 0, 0, 32'h00800000)); // min normal
    dirs.push_back(mk(0, 127, 48'h400000000000, 2, 1, 1, 0, 32'h7FC00000)); // nan+inf
    dirs.push_back(mk(0, 127, 48'h400000000000, 2, 0, 1, 1, 32'h7F800000)); // inf beats zero
    dirs.push_back(mk(1, 127, 48'h400000000000, 2, 0, 0, 1, 32'h80000000)); // zero
    dirs.push_back(mk(1, 127, 48'h000000000000, 2, 0, 0, 0, 32'h80000000)); // prod==0

    foreach (dirs[i]) begin
      check32("model_pin", model(dirs[i].sign, dirs[i].exp, dirs[i].prod, dirs[i].shift,
                                 dirs[i].nan, dirs[i].inf, dirs[i].zero), dirs[i].expv);
      drive(dirs[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check1("dir_latency_valid", out_valid, 1'b1);
      check32("dir_data", out_data, dirs[i].expv);
    end
    @(posedge clk); #1;

    // Back-to-back stream under random backpressure.
    begin
      int idx;
      int cyc;
      int p0;
      logic acc;
      vec_t sq[8];
      for (int k = 0; k < 8; k++) begin
        sq[k].sign  = 1'($urandom);
        sq[k].prod  = {16'($urandom), 32'($urandom)} | 48'h400000000000;
        sq[k].shift = sq[k].prod[47] ? 1 : 2;
        sq[k].exp   = int'($urandom_range(1, 250));
        sq[k].nan   = 1'b0; sq[k].inf = 1'b0; sq[k].zero = 1'b0;
        sq[k].expv  = 32'h0;
      end
      p0 = popped; idx = 0; cyc = 0;
      drive(sq[0]);
      in_valid = 1'b1;
      out_ready = 1'($urandom);
      while (idx < 8 && cyc < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        if (acc) begin
          idx++;
          if (idx < 8) drive(sq[idx]);
          else in_valid = 1'b0;
        end
        out_ready = 1'($urandom);
        cyc++;
      end
      in_valid = 1'b0;
      check1("stream_accept_in_time", (idx == 8), 1'b1);
      out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      @(posedge clk); #1;
      check32("stream_count", 32'(popped - p0), 32'd8);
      check1("stream_drained_valid", out_valid, 1'b0);
    end

    // Reset with two results in flight.
    out_ready = 1'b0;
    drive(dirs[0]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(dirs[1]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check1("rst_pre_valid", out_valid, 1'b1);
    check1("rst_pre_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_out_data", out_data, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check1("rst_no_stale", out_valid, 1'b0);
    end
    check1("rst_in_ready", in_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
